button_event_decoder: RTL and testbench

- Downstream consumer of the debouncer: takes the clean, registered debounced button level and classifies it into single-cycle event pulses: press, release, short click, double click and long press.
- Feeds control FSMs and counters that need discrete button events rather than a level.
- Pure synchronous FSM with one shared duration counter.

---
 rtl/button_event_decoder_pkg.sv | 17 +
 rtl/button_event_decoder_edge_detect.sv | 23 ++
 rtl/button_event_decoder.sv | 149 ++++++++++++++
 tb/tb_button_event_decoder.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/button_event_decoder_pkg.sv
// rtl/button_event_decoder_pkg.sv - shared state encoding and default timing for the button event decoder
package button_event_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PRESS1    = 3'd1,
    GAP       = 3'd2,
    PRESS2    = 3'd3,
    LONG_HELD = 3'd4
  } state_e;

  localparam int DEF_LONG_CYCLES    = 1000;
  localparam int DEF_DBL_GAP_CYCLES = 300;
  localparam int DEF_REPEAT_CYCLES  = 200;
  localparam int DEF_CNT_W          = 16;

endpackage

// File: rtl/button_event_decoder_edge_detect.sv
// rtl/button_event_decoder_edge_detect.sv - registered rise/fall detector for a level already synchronous to clk
module edge_detect (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic rise_o,
  output logic fall_o
);

  logic btn_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      btn_q <= 1'b0;
    end else begin
      btn_q <= btn_i;
    end
  end

  assign rise_o = btn_i & ~btn_q;
  assign fall_o = ~btn_i & btn_q;

endmodule

// File: rtl/button_event_decoder.sv
// rtl/button_event_decoder.sv - classifies a debounced button level into press/release/click/long events
// Optional auto-repeat of long_press while held: define BUTTON_EVENT_REPEAT_EN.
module button_event_decoder
  import button_event_pkg::*;
#(
  parameter int LONG_CYCLES    = DEF_LONG_CYCLES,
  parameter int DBL_GAP_CYCLES = DEF_DBL_GAP_CYCLES,
  parameter int CNT_W          = DEF_CNT_W,
  parameter int REPEAT_CYCLES  = DEF_REPEAT_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press_pulse,
  output logic release_pulse,
  output logic short_click,
  output logic double_click,
  output logic long_press,
  output logic held
);

  localparam logic [CNT_W-1:0] LONG_M1 = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_M1  = CNT_W'(DBL_GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  if ((LONG_CYCLES < 2) || (DBL_GAP_CYCLES < 2) || (REPEAT_CYCLES < 1) ||
      (longint'(LONG_CYCLES) > longint'(CNT_MAX)) ||
      (longint'(DBL_GAP_CYCLES) > longint'(CNT_MAX))) begin : g_bad_cfg
    $error("button_event_decoder: illegal timing parameters");
  end

  logic rise, fall;

  edge_detect u_edge (
    .clk_i  (clk),
    .rst_ni (rst),
    .btn_i  (btn),
    .rise_o (rise),
    .fall_o (fall)
  );

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic             short_d, double_d, long_d;
  logic             press_q, release_q, short_q, double_q, long_q, held_q;

  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

  // A fall is always checked before the long threshold so a release on the
  // threshold cycle keeps the short/double classification.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    short_d  = 1'b0;
    double_d = 1'b0;
    long_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (rise) begin
          state_d = PRESS1;
          cnt_d   = '0;
        end
      end
      PRESS1, PRESS2: begin
        if (fall) begin
          cnt_d = '0;
          if (state_q == PRESS1) begin
            state_d = GAP;
          end else begin
            state_d  = IDLE;
            double_d = 1'b1;
          end
        end else if (btn) begin
          if (cnt_q == LONG_M1) begin
            state_d = LONG_HELD;
            long_d  = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      GAP: begin
        if (rise) begin
          state_d = PRESS2;
          cnt_d   = '0;
        end else if (cnt_q == GAP_M1) begin
          state_d = IDLE;
          short_d = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      LONG_HELD: begin
        if (fall) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
`ifdef BUTTON_EVENT_REPEAT_EN
        // Counter restarts at the initial long_press, so repeats land every REPEAT_CYCLES after it.
        else if (btn) begin
          if (cnt_q == CNT_W'(REPEAT_CYCLES - 1)) begin
            long_d = 1'b1;
            cnt_d  = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
`endif
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      short_q   <= 1'b0;
      double_q  <= 1'b0;
      long_q    <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      press_q   <= rise;
      release_q <= fall;
      short_q   <= short_d;
      double_q  <= double_d;
      long_q    <= long_d;
      held_q    <= (state_d == LONG_HELD);
    end
  end

  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign short_click   = short_q;
  assign double_click  = double_q;
  assign long_press    = long_q;
  assign held          = held_q;

endmodule

// File: tb/tb_button_event_decoder.sv
// tb/tb_button_event_decoder.sv - self-checking bench for button_event_decoder against a run-length model
module tb_button_event_decoder;

  localparam int LONG = 8;
  localparam int DGAP = 4;
  localparam int REP  = 3;

  logic clk = 1'b0;
  logic rst;
  logic btn;
  logic press_pulse, release_pulse, short_click, double_click, long_press, held;

  button_event_decoder #(
    .LONG_CYCLES    (LONG),
    .DBL_GAP_CYCLES (DGAP),
    .CNT_W          (8),
    .REPEAT_CYCLES  (REP)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .btn           (btn),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .short_click   (short_click),
    .double_click  (double_click),
    .long_press    (long_press),
    .held          (held)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Model: tracks run lengths of high/low samples and pending-click flags.
  int run = 0, low_run = 0;
  bit prev = 0, pending = 0, in_second = 0, long_fired = 0;
  bit e_press, e_rel, e_short, e_dbl, e_long, e_held;

  int cyc_g = 0;
  int n_short = 0, n_dbl = 0, n_long = 0;
  int last_press = -1, last_rel = -1, last_short = -1, last_dbl = -1, last_long = -1, last_held = -1;

  always begin
    @(posedge clk);
    cyc_g++;
    {e_press, e_rel, e_short, e_dbl, e_long, e_held} = '0;
    if (!rst) begin
      run = 0; low_run = 0; prev = 0; pending = 0; in_second = 0; long_fired = 0;
    end else begin
      if (btn && !prev) begin
        e_press = 1; run = 1; in_second = pending; pending = 0; long_fired = 0;
      end else if (btn) begin
        run++;
        if (!long_fired && run == LONG + 1) begin
          e_long = 1; long_fired = 1;
        end
`ifdef BUTTON_EVENT_REPEAT_EN
        else if (long_fired && ((run - LONG - 1) % REP) == 0) begin
          e_long = 1;
        end
`endif
      end else if (prev) begin
        e_rel = 1;
        if (!long_fired) begin
          if (in_second) e_dbl = 1;
          else begin pending = 1; low_run = 1; end
        end
        long_fired = 0; in_second = 0; run = 0;
      end else if (pending) begin
        low_run++;
        if (low_run == DGAP + 1) begin e_short = 1; pending = 0; end
      end
      e_held = long_fired && btn;
      prev = btn;
    end
    #1;
    chk("press_pulse",   press_pulse,   e_press);
    chk("release_pulse", release_pulse, e_rel);
    chk("short_click",   short_click,   e_short);
    chk("double_click",  double_click,  e_dbl);
    chk("long_press",    long_press,    e_long);
    chk("held",          held,          e_held);
    if (press_pulse === 1'b1)   last_press = cyc_g;
    if (release_pulse === 1'b1) last_rel = cyc_g;
    if (short_click === 1'b1)  begin n_short++; last_short = cyc_g; end
    if (double_click === 1'b1) begin n_dbl++;   last_dbl = cyc_g;   end
    if (long_press === 1'b1)   begin n_long++;  last_long = cyc_g;  end
    if (held === 1'b1)         last_held = cyc_g;
  end

  task automatic drive(input logic v, input int n);
    repeat (n) begin
      btn = v;
      @(negedge clk);
    end
  endtask

  int s, s_short, s_dbl, s_long;

  task automatic snap();
    s = cyc_g; s_short = n_short; s_dbl = n_dbl; s_long = n_long;
  endtask

  initial begin
    rst = 1'b0;
    btn = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {press_pulse, release_pulse, short_click, double_click, long_press, held}, 0);

    snap();
    rst = 1'b1;
    drive(1, 2); drive(0, 8);
    chk("press_after_reset", last_press - s, 1);

    snap();
    drive(1, 3); drive(0, 8);
    chk("short_count", n_short - s_short, 1);
    chk("short_rel_at", last_rel - s, 4);
    chk("short_latency", last_short - last_rel, 4);
    chk("short_no_dbl_long", (n_dbl - s_dbl) + (n_long - s_long), 0);

    snap();
    drive(1, 2); drive(0, 2); drive(1, 2); drive(0, 8);
    chk("dbl_count", n_dbl - s_dbl, 1);
    chk("dbl_at", last_dbl - s, 7);
    chk("dbl_no_short", n_short - s_short, 0);

    snap();
    drive(1, 10); drive(0, 8);
    chk("long_count", n_long - s_long, 1);
    chk("long_at", last_long - s, 9);
    chk("held_last", last_held - s, 10);
    chk("long_no_clicks", (n_short - s_short) + (n_dbl - s_dbl), 0);

    snap();
    drive(1, 8); drive(0, 8);
    chk("boundary_no_long", n_long - s_long, 0);
    chk("boundary_short", n_short - s_short, 1);

    snap();
    drive(1, 2); drive(0, 4); drive(1, 2); drive(0, 8);
    chk("gap_edge_dbl", n_dbl - s_dbl, 1);
    chk("gap_edge_no_short", n_short - s_short, 0);

    snap();
    drive(1, 2); drive(0, 5); drive(1, 2); drive(0, 8);
    chk("gap_over_short", n_short - s_short, 2);
    chk("gap_over_no_dbl", n_dbl - s_dbl, 0);

    snap();
    drive(1, 16); drive(0, 8);
`ifdef BUTTON_EVENT_REPEAT_EN
    chk("repeat_count", n_long - s_long, 3);
    chk("repeat_last", last_long - s, 15);
`else
    chk("repeat_count", n_long - s_long, 1);
    chk("repeat_last", last_long - s, 9);
`endif

    snap();
    drive(1, 2); drive(0, 2);
    rst = 1'b0;
    drive(0, 2);
    rst = 1'b1;
    drive(0, 8);
    chk("midreset_no_short", n_short - s_short, 0);

    for (int i = 0; i < 200; i++) begin
      int h, l;
      h = $urandom_range(1, 12);
      l = $urandom_range(1, 8);
      if ($urandom_range(0, 19) == 0) begin
        drive(1, h / 2 + 1);
        rst = 1'b0;
        drive($urandom_range(0, 1), 2);
        rst = 1'b1;
      end else begin
        drive(1, h);
      end
      drive(0, l);
    end
    drive(0, 10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
